// File: rtl/key_num_ctrl.sv
// key_num_ctrl: turns debounced key press events into 4-digit BCD edits.
// Define KEY_REPEAT_EN to build the hold-to-auto-repeat FSM for inc/dec.
module key_num_ctrl #(
   parameter int unsigned LONG_CYC = 25_000_000,
   parameter int unsigned REP_CYC  = 5_000_000,
   parameter int unsigned CNT_W    = 25
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  keyvalue,
   input  logic        keyflag,
   output logic [15:0] num,
   output logic [1:0]  cursor,
   output logic        num_vld
);

   typedef enum logic [2:0] {
      OP_NONE,
      OP_INC,
      OP_DEC,
      OP_CUR,
      OP_CLR
   } op_t;

   logic [3:0]  r_prev;
   logic [15:0] r_num;
   logic [1:0]  r_cur;
   logic        r_vld;

   logic [3:0]  w_press;
   op_t         w_key_op;
   op_t         w_op;
   logic [3:0]  w_dig;
   logic [3:0]  w_dig_nx;
   logic [15:0] w_num_nx;
   logic [1:0]  w_cur_nx;

   assign w_press = keyflag ? (r_prev & ~keyvalue) : 4'b0000;

   // Several keys falling together: highest index wins.
   always_comb begin
      w_key_op = OP_NONE;
      priority case (1'b1)
         w_press[3]: w_key_op = OP_CLR;
         w_press[2]: w_key_op = OP_CUR;
         w_press[1]: w_key_op = OP_DEC;
         w_press[0]: w_key_op = OP_INC;
         default:    w_key_op = OP_NONE;
      endcase
   end

`ifdef KEY_REPEAT_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_REPEAT
   } st_t;

   localparam logic [CNT_W-1:0] L_LONG = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] L_REP  = CNT_W'(REP_CYC - 1);
   localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

   st_t              r_st;
   st_t              w_st_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             r_rep;
   logic             w_rep_nx;
   logic             w_tick;
   logic             w_new_rep;
   logic             w_rel;

   assign w_new_rep = (w_key_op == OP_INC) || (w_key_op == OP_DEC);
   assign w_rel     = r_rep ? keyvalue[1] : keyvalue[0];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_st  <= S_IDLE;
         r_cnt <= '0;
         r_rep <= 1'b0;
      end else begin
         r_st  <= w_st_nx;
         r_cnt <= w_cnt_nx;
         r_rep <= w_rep_nx;
      end
   end

   // Hold time is measured from the press cycle itself, so entry loads 1.
   always_comb begin
      w_st_nx  = r_st;
      w_cnt_nx = r_cnt;
      w_rep_nx = r_rep;
      w_tick   = 1'b0;
      unique case (r_st)
         S_IDLE: begin
            if (w_new_rep) begin
               w_st_nx  = S_HOLD;
               w_rep_nx = (w_key_op == OP_DEC);
               w_cnt_nx = L_ONE;
            end
         end
         default: begin
            if (r_cnt == ((r_st == S_HOLD) ? L_LONG : L_REP)) begin
               w_tick   = 1'b1;
               w_cnt_nx = '0;
               w_st_nx  = S_REPEAT;
            end else begin
               w_cnt_nx = r_cnt + L_ONE;
            end
            if (keyflag && w_rel) begin
               w_st_nx  = S_IDLE;
               w_cnt_nx = '0;
               w_tick   = 1'b0;
            end else if (w_new_rep) begin
               w_st_nx  = S_HOLD;
               w_rep_nx = (w_key_op == OP_DEC);
               w_cnt_nx = L_ONE;
               w_tick   = 1'b0;
            end
         end
      endcase
   end

   // A strobe edit overrides a coincident repeat tick.
   assign w_op = (w_key_op != OP_NONE) ? w_key_op :
                 w_tick ? (r_rep ? OP_DEC : OP_INC) : OP_NONE;
`else
   assign w_op = w_key_op;
`endif

   always_comb begin
      w_dig    = r_num[{r_cur, 2'b00} +: 4];
      w_dig_nx = w_dig;
      w_num_nx = r_num;
      w_cur_nx = r_cur;
      unique case (w_op)
         OP_INC: begin
            w_dig_nx = (w_dig >= 4'd9) ? 4'd0 : w_dig + 4'd1;
            w_num_nx[{r_cur, 2'b00} +: 4] = w_dig_nx;
         end
         OP_DEC: begin
            w_dig_nx = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
            w_num_nx[{r_cur, 2'b00} +: 4] = w_dig_nx;
         end
         OP_CUR: w_cur_nx = r_cur + 2'd1;
         OP_CLR: begin
            w_num_nx = '0;
            w_cur_nx = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_prev <= 4'b1111;
         r_num  <= '0;
         r_cur  <= '0;
         r_vld  <= 1'b0;
      end else begin
         if (keyflag) r_prev <= keyvalue;
         r_num <= w_num_nx;
         r_cur <= w_cur_nx;
         r_vld <= (w_op != OP_NONE);
      end
   end

   assign num     = r_num;
   assign cursor  = r_cur;
   assign num_vld = r_vld;

endmodule
